// File: rtl/dm_store_buffer.sv
// dm_store_buffer: MEM-stage store queue. Turns sb/sh/sw requests into
// word-aligned address, byte-enable and lane-replicated data, holds them in a
// small FIFO and drains them to the data-memory write port over req/ack.
// Also reports loads that hit a word still pending in the buffer.
module dm_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [1:0]        DMWOp,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              st_ready,
  output logic              st_misalign,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_conflict,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_SB = 2'd1;
  localparam logic [1:0] OP_SH = 2'd2;
  localparam logic [1:0] OP_SW = 2'd3;

  // Byte-lane enable for a store of kind op at byte offset off within the word.
  function automatic logic [3:0] lane_be(input logic [1:0] op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      OP_SB:   be = 4'b0001 << off;
      OP_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low byte/half of the raw register value across every lane,
  // so the byte enables alone select what memory actually writes.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      OP_SW:   r = d;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  vld_p1;
  logic [29:0]       waddr_p1 [DEPTH];
  logic [3:0]        be_p1    [DEPTH];
  logic [DATA_W-1:0] data_p1  [DEPTH];

  logic enq, deq;

  // The low byte-offset bits of a load do not matter for word matching.
  logic unused_ld_off;
  assign unused_ld_off = ^ld_addr[1:0];

  assign st_misalign = st_valid & (((DMWOp == OP_SH) & addr[0]) |
                                   ((DMWOp == OP_SW) & (addr[1:0] != 2'b00)));
  assign st_ready    = (count != CW'(DEPTH));
  assign mem_req     = (count != '0);
  assign enq         = st_valid & (DMWOp != 2'd0) & ~st_misalign & st_ready;
  assign deq         = mem_req & mem_ack;

  // Head entry drives the write port; all-zero while the buffer is empty.
  always_comb begin
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_addr  = {waddr_p1[head], 2'b00};
      mem_be    = be_p1[head];
      mem_wdata = data_p1[head];
    end
  end

  // A load conflicts with any occupied entry of the same word, including the
  // head being retired this very cycle.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_p1[i] && (waddr_p1[i] == ld_addr[31:2])) ld_conflict = ld_valid;
    end
  end

  // Control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      vld_p1 <= '0;
    end else begin
      if (deq) begin
        head         <= head + PW'(1);
        vld_p1[head] <= 1'b0;
      end
      if (enq) begin
        tail         <= tail + PW'(1);
        vld_p1[tail] <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload: written at the tail on enqueue, never reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      waddr_p1[tail] <= addr[31:2];
      be_p1[tail]    <= lane_be(DMWOp, addr[1:0]);
      data_p1[tail]  <= lane_data(DMWOp, wdata);
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  DMWOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        st_ready;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  dm_store_buffer #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .DMWOp(DMWOp), .addr(addr),
    .wdata(wdata), .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mis(input logic v, input logic [1:0] op, input logic [31:0] a);
    return v && ((op == 2 && a[0]) || (op == 3 && a[1:0] != 0));
  endfunction

  function automatic ent_t m_enc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.a = {a[31:2], 2'b00};
    if (op == 1) begin
      e.be = 4'(1 << a[1:0]);
      e.d  = {d[7:0], d[7:0], d[7:0], d[7:0]};
    end else if (op == 2) begin
      e.be = a[1] ? 4'hC : 4'h3;
      e.d  = {d[15:0], d[15:0]};
    end else begin
      e.be = 4'hF;
      e.d  = d;
    end
    return e;
  endfunction

  // Reference model: retire head on ack, append accepted stores.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      started = 1;
    end else if (started) begin
      bit do_enq;
      do_enq = st_valid && DMWOp != 0 && !m_mis(st_valid, DMWOp, addr) && q.size() != DEPTH;
      if (q.size() != 0 && mem_ack) void'(q.pop_front());
      if (do_enq) q.push_back(m_enc(DMWOp, addr, wdata));
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      bit conf;
      conf = 0;
      foreach (q[i]) if (q[i].a[31:2] == ld_addr[31:2]) conf = 1;
      chk("mem_req", {31'b0, mem_req}, {31'b0, q.size() != 0});
      chk("st_ready", {31'b0, st_ready}, {31'b0, q.size() != DEPTH});
      chk("mem_addr", mem_addr, q.size() != 0 ? q[0].a : 32'h0);
      chk("mem_be", {28'b0, mem_be}, q.size() != 0 ? {28'b0, q[0].be} : 32'h0);
      chk("mem_wdata", mem_wdata, q.size() != 0 ? q[0].d : 32'h0);
      chk("st_misalign", {31'b0, st_misalign}, {31'b0, m_mis(st_valid, DMWOp, addr)});
      chk("ld_conflict", {31'b0, ld_conflict}, {31'b0, ld_valid && conf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    DMWOp    = op;
    addr     = a;
    wdata    = d;
  endtask

  task automatic idle_store();
    st_valid = 1'b0;
    DMWOp    = 2'd0;
    addr     = 32'h0;
    wdata    = 32'h0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 0; DMWOp = 0; addr = 0; wdata = 0;
    ld_valid = 0; ld_addr = 0; mem_ack = 0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_st_ready", {31'b0, st_ready}, 32'h1);
    reset = 1'b0;

    // Byte lanes drained with ack held high.
    mem_ack = 1'b1;
    store(1, 32'h1001, 32'h000000A5); tick(); #1;
    chk("sb1_addr", mem_addr, 32'h1000);
    chk("sb1_be", {28'b0, mem_be}, 32'h2);
    chk("sb1_data", mem_wdata, 32'hA5A5A5A5);
    store(1, 32'h1002, 32'h000000A5); tick(); #1;
    chk("sb2_be", {28'b0, mem_be}, 32'h4);
    store(1, 32'h1003, 32'h000000A5); tick(); #1;
    chk("sb3_be", {28'b0, mem_be}, 32'h8);
    chk("sb3_data", mem_wdata, 32'hA5A5A5A5);
    store(2, 32'h1002, 32'h00001234); tick(); #1;
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_data", mem_wdata, 32'h12341234);
    idle_store(); tick(); tick();
    chk("lanes_drained", {31'b0, mem_req}, 32'h0);

    // Misaligned stores are flagged and dropped; sb never misaligns.
    mem_ack = 1'b0;
    store(2, 32'h2001, 32'h1); #1;
    chk("sh_mis", {31'b0, st_misalign}, 32'h1);
    tick();
    chk("sh_mis_noenq", {31'b0, mem_req}, 32'h0);
    store(3, 32'h2002, 32'h2); #1;
    chk("sw_mis", {31'b0, st_misalign}, 32'h1);
    tick();
    chk("sw_mis_noenq", {31'b0, mem_req}, 32'h0);
    store(1, 32'h2003, 32'h77); #1;
    chk("sb_nomis", {31'b0, st_misalign}, 32'h0);
    tick();
    chk("sb_enq_be", {28'b0, mem_be}, 32'h8);
    chk("sb_enq_data", mem_wdata, 32'h77777777);
    idle_store(); mem_ack = 1'b1; tick(); mem_ack = 1'b0;

    // Full buffer refuses the 5th store until a slot is freed.
    for (int i = 0; i < 4; i++) begin
      store(3, 32'h4000 + 32'(4 * i), 32'h11110000 + 32'(i)); tick();
    end
    chk("full_ready", {31'b0, st_ready}, 32'h0);
    store(3, 32'h4010, 32'h5); tick();
    chk("full_refused_head", mem_addr, 32'h4000);
    mem_ack = 1'b1; #1;
    chk("full_ack_ready", {31'b0, st_ready}, 32'h0);
    tick();
    chk("after_pulse_ready", {31'b0, st_ready}, 32'h1);
    chk("after_pulse_head", mem_addr, 32'h4004);
    mem_ack = 1'b0; tick();
    chk("refill_ready", {31'b0, st_ready}, 32'h0);
    idle_store(); mem_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("drain_order", mem_addr, 32'h4000 + 32'(4 * i));
      tick();
    end
    chk("full_drained", {31'b0, mem_req}, 32'h0);

    // Simultaneous enqueue and dequeue keeps occupancy; then wrap the pointers.
    mem_ack = 1'b0;
    store(3, 32'h5000, 32'hA0); tick();
    store(3, 32'h5004, 32'hA1); tick();
    store(3, 32'h5008, 32'hA2); mem_ack = 1'b1; tick();
    chk("simul_head", mem_addr, 32'h5004);
    chk("simul_ready", {31'b0, st_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      store(3, 32'h6000 + 32'(4 * i), 32'hC0DE0000 + 32'(i)); tick();
    end
    idle_store();
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_drained", {31'b0, mem_req}, 32'h0);

    // Load conflict against a pending word.
    mem_ack = 1'b0;
    store(3, 32'h3004, 32'hDEADBEEF); tick();
    idle_store();
    ld_valid = 1'b1; ld_addr = 32'h3006; #1;
    chk("ld_hit", {31'b0, ld_conflict}, 32'h1);
    ld_addr = 32'h3008; #1;
    chk("ld_miss", {31'b0, ld_conflict}, 32'h0);
    ld_addr = 32'h3006; mem_ack = 1'b1; #1;
    chk("ld_hit_retiring", {31'b0, ld_conflict}, 32'h1);
    tick(); mem_ack = 1'b0; #1;
    chk("ld_after_retire", {31'b0, ld_conflict}, 32'h0);
    ld_valid = 1'b0; ld_addr = 32'h0;

    // Reset mid-drain discards everything pending.
    for (int i = 0; i < 3; i++) begin
      store(3, 32'h7000 + 32'(4 * i), 32'h70 + 32'(i)); tick();
    end
    idle_store();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mid_be", {28'b0, mem_be}, 32'h0);
    chk("rst_mid_ready", {31'b0, st_ready}, 32'h1);
    store(3, 32'h8000, 32'h0000ABCD); tick();
    idle_store();
    chk("post_rst_head", mem_addr, 32'h8000);
    chk("post_rst_data", mem_wdata, 32'h0000ABCD);
    mem_ack = 1'b1; tick();
    chk("post_rst_alone", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store-side companion to the load data extractor in the MEM stage. Accepts sb/sh/sw requests from the pipeline and converts each one into a word-aligned address, a byte-enable mask and replicated write data. Queues them in a small FIFO and drains them to the data-memory write port over a req/ack handshake. Also flags loads that hit a word still pending in the buffer, so hazard control can stall them.

## Interface
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  MEM stage presents a store this cycle
- DMWOp  input  2  store kind: 0 none, 1 sb, 2 sh, 3 sw
- addr  input  32  byte address of the store
- wdata  input  32  raw rt value, unshifted
- st_ready  output  1  buffer can accept a store this cycle
- st_misalign  output  1  current store request is misaligned (combinational)
- ld_valid  input  1  MEM stage presents a load this cycle
- ld_addr  input  32  byte address of that load
- ld_conflict  output  1  load word address matches a pending entry (combinational)
- mem_req  output  1  head entry valid, write requested
- mem_addr  output  32  head word address, bits [1:0] = 0
- mem_be  output  4  head byte enables, bit i = byte lane i (data[8i+7:8i])
- mem_wdata  output  32  head write data
- mem_ack  input  1  memory accepts the head write this cycle

## Operation
- Lane encoding, with off = addr[1:0]:
  - sb: be = 4'b0001 << off; data = {4{wdata[7:0]}}.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - sw: be = 4'b1111; data = wdata.
- Misalignment: st_misalign = st_valid & ((DMWOp==2 & addr[0]) | (DMWOp==3 & addr[1:0]!=0)).
  - A misaligned store is never enqueued; raising the exception is the pipeline's job.
  - sb is never misaligned. DMWOp==0 never enqueues and never flags.
- Enqueue condition: st_valid & DMWOp!=0 & !st_misalign & st_ready.
  - Writes {addr[31:2], 2'b00}, be and data into the tail entry and advances the tail pointer modulo DEPTH.
- Dequeue condition: mem_req & mem_ack. Advances the head pointer modulo DEPTH.
- Occupancy: a count register (0..DEPTH) is incremented on enqueue only, decremented on dequeue only, and unchanged when both occur in the same cycle.
- st_ready = (count != DEPTH).
  - There is no full-bypass: when full, a store is refused even if a dequeue happens in the same cycle.
  - The pipeline holds the store and retries.
- mem_req = (count != 0).
  - While mem_req is 1, mem_addr, mem_be and mem_wdata show the head entry and must stay stable until the ack.
  - While empty, mem_addr = 0, mem_be = 0 and mem_wdata = 0.
- ld_conflict = ld_valid & (some occupied entry has word address == ld_addr[31:2]).
  - Only occupied entries count; an entry dequeued this cycle still counts this cycle.
  - A store being enqueued in the same cycle is not compared.
- Entries drain strictly in FIFO order; there is no merging or coalescing of stores.

## Timing
- Reset (synchronous): count = 0, head = tail = 0, and entry valid bits clear.
  - Outputs after reset: mem_req = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0, st_ready = 1.
- A store enqueued at edge N is visible on mem_req/mem_* from cycle N+1 when the buffer was empty: 1-cycle latency.
- mem_ack may be held high continuously; the buffer then retires one entry per cycle.
- mem_ack while mem_req = 0 is ignored.
- Reset asserted mid-drain discards all pending entries. In-flight writes are not completed.
- st_misalign and ld_conflict are purely combinational from the current inputs and state; they carry no registered delay.
- Pointer wrap: after DEPTH enqueues, tail returns to 0. Full and empty are told apart by count, never by pointer equality.

## Test plan
- Byte store lanes: sb at 0x1001, 0x1002 and 0x1003 with wdata=0x000000A5, then sh at 0x1002 with wdata 0x1234, all drained with mem_ack held high.
  - sb: mem_addr=0x1000 each time; be=0010, 0100, 1000; mem_wdata=0xA5A5A5A5.
  - sh: be=1100, mem_wdata=0x12341234.
- Misalign: sh at 0x2001 -> st_misalign=1 and count stays unchanged; sw at 0x2002 -> st_misalign=1; sb at 0x2003 -> st_misalign=0 and the store is enqueued.
- Full: enqueue 4 sw with mem_ack=0 -> st_ready=0 and the 5th store is refused. Pulse mem_ack for one cycle with the 5th store held:
  - head retires and count=3 for one cycle;
  - the store is accepted on the next edge and count=4;
  - entries drain in order afterwards.
- Simultaneous: with count=2, enqueue and ack in the same cycle -> count stays 2 and the head advances. Run 10 stores through continuous ack to exercise pointer wrap; data order must be preserved.
- Load conflict: store sw 0x3004 pending, then ld_addr=0x3006 -> ld_conflict=1. ld_addr=0x3008 -> ld_conflict=0. After the ack retires the entry -> ld_conflict=0 for 0x3006.
- Reset mid-drain: 3 entries pending, assert reset for one cycle -> next cycle mem_req=0, mem_be=0, st_ready=1, and the following store appears at the head alone.
